// File: rtl/zapper_frame_monitor_if.sv
// Video/result bundle between a VGA source and the light-gun frame monitor.
// master: the video source and trigger side; slave: the frame monitor.
interface zapper_frame_monitor_if #(
    parameter int CW = 10
);
    logic          pix_en;
    logic          hSync;
    logic          vSync;
    logic          vgaBlankn;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic          arm;
    logic          busy;
    logic          done;
    logic          hit;
    logic [CW-1:0] hit_x;
    logic [CW-1:0] hit_y;
    logic          frame_err;
    logic [18:0]   hit_count;

    modport master (
        output pix_en, hSync, vSync, vgaBlankn, r, g, b, arm,
        input  busy, done, hit, hit_x, hit_y, frame_err, hit_count
    );

    modport slave (
        input  pix_en, hSync, vSync, vgaBlankn, r, g, b, arm,
        output busy, done, hit, hit_x, hit_y, frame_err, hit_count
    );
endinterface

// File: rtl/zapper_frame_monitor.sv
// Light-gun sensor model: after an arm pulse, captures the next VGA frame,
// recovers pixel coordinates from vSync/vgaBlankn and reports the first pixel
// whose luma reaches THRESH, plus a frame timing error flag.
// Optional macro HIT_COUNT_EN: when defined, hit_count counts every bright
// active pixel of the captured frame; otherwise hit_count is tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | result held, waiting for arm
// WAIT_VS | armed, waiting for the end of the vertical sync pulse
// CAPTURE | tracking x/y through the frame, looking for a bright pixel
// DONE    | frame finished; pulse done and drop busy
module zapper_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int THRESH   = 200,
    parameter int CW       = 10
) (
    input logic                    clk,
    input logic                    reset,
    zapper_frame_monitor_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    localparam logic [CW-1:0] CMAX  = '1;
    localparam logic [CW-1:0] H_LEN = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_LEN = CW'(V_ACTIVE);
    // luma >= THRESH with luma = sum >> 2 is the same as sum >= 4*THRESH
    localparam logic [9:0]    LUMA_MIN = 10'(THRESH * 4);

    state_t        state;
    logic          vs_q;
    logic          bl_q;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          busy_r;
    logic          done_r;
    logic          hit_r;
    logic          err_r;
    logic [CW-1:0] hx_r;
    logic [CW-1:0] hy_r;

    logic [9:0]    luma_sum;
    logic          bright;
    logic          act;
    logic          vs_rise;
    logic          vs_fall;
    logic          bl_fall;
    logic          arm_accept;
    logic [CW-1:0] y_nxt;
    logic          y_ovf;

    assign luma_sum   = {2'b00, bus.r} + {1'b0, bus.g, 1'b0} + {2'b00, bus.b};
    assign bright     = (luma_sum >= LUMA_MIN);
    assign act        = bus.pix_en & bus.vgaBlankn;
    assign vs_rise    = bus.pix_en & ~vs_q & bus.vSync;
    assign vs_fall    = bus.pix_en & vs_q & ~bus.vSync;
    assign bl_fall    = bus.pix_en & bl_q & ~bus.vgaBlankn;
    // done is still high on the first IDLE cycle; an arm there is dropped
    assign arm_accept = (state == IDLE) & bus.arm & ~done_r;

    // Line counter advance at end of each active line, saturating at CMAX
    always_comb begin
        y_nxt = y;
        y_ovf = 1'b0;
        if (bl_fall) begin
            if (y == CMAX) y_ovf = 1'b1;
            else           y_nxt = y + CW'(1);
        end
    end

    // Previous sync/blank levels, sampled only on pixel strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q <= 1'b1;
            bl_q <= 1'b1;
        end else if (bus.pix_en) begin
            vs_q <= bus.vSync;
            bl_q <= bus.vgaBlankn;
        end
    end

    // Capture sequencer with registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hit_r  <= 1'b0;
            err_r  <= 1'b0;
            hx_r   <= '0;
            hy_r   <= '0;
            x      <= '0;
            y      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm_accept) begin
                        state  <= WAIT_VS;
                        busy_r <= 1'b1;
                        hit_r  <= 1'b0;
                        err_r  <= 1'b0;
                        hx_r   <= '0;
                        hy_r   <= '0;
                    end
                end
                WAIT_VS: begin
                    if (vs_rise) begin
                        state <= CAPTURE;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                CAPTURE: begin
                    if (act) begin
                        if (bright && !hit_r) begin
                            hit_r <= 1'b1;
                            hx_r  <= x;
                            hy_r  <= y;
                        end
                        if (x == CMAX) err_r <= 1'b1;
                        else           x     <= x + CW'(1);
                    end else if (bl_fall) begin
                        if (x != H_LEN) err_r <= 1'b1;
                        x <= '0;
                    end
                    y <= y_nxt;
                    if (y_ovf) err_r <= 1'b1;
                    if (vs_fall) begin
                        if (y_nxt != V_LEN) err_r <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.hit       = hit_r;
    assign bus.hit_x     = hx_r;
    assign bus.hit_y     = hy_r;
    assign bus.frame_err = err_r;

`ifdef HIT_COUNT_EN
    logic [18:0] hcnt;

    // Saturating count of bright active pixels in the captured frame
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
        end else if (arm_accept) begin
            hcnt <= '0;
        end else if (state == CAPTURE && act && bright && hcnt != '1) begin
            hcnt <= hcnt + 19'd1;
        end
    end

    assign bus.hit_count = hcnt;
`else
    assign bus.hit_count = '0;
`endif

endmodule

// File: tb/tb_zapper_frame_monitor.sv
// Directed bench for zapper_frame_monitor on a reduced 32x24 raster.
module tb_zapper_frame_monitor;

    localparam int H  = 32;
    localparam int V  = 24;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   gap = 0;
    int   arm_row = -1;
    int   reset_row = -1;
    int   spot_x[$];
    int   spot_y[$];
    int   spot_v[$];
    int   dc0;

    zapper_frame_monitor_if #(.CW(CW)) bus ();

    zapper_frame_monitor #(
        .H_ACTIVE(H), .V_ACTIVE(V), .THRESH(200), .CW(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef HIT_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [7:0] level_at(input int px, input int py);
        for (int i = 0; i < spot_x.size(); i++)
            if (spot_x[i] == px && spot_y[i] == py) return 8'(spot_v[i]);
        return 8'd0;
    endfunction

    // one pixel with pix_en high, then 'gap' strobe-less cycles of garbage
    task automatic pix(input logic vs, input logic hs, input logic bl, input logic [7:0] lv);
        bus.pix_en = 1'b1;
        bus.vSync = vs; bus.hSync = hs; bus.vgaBlankn = bl;
        bus.r = lv; bus.g = lv; bus.b = lv;
        @(posedge clk); #1;
        for (int i = 0; i < gap; i++) begin
            bus.pix_en = 1'b0;
            bus.vSync = ~vs; bus.vgaBlankn = 1'b1;
            bus.r = 8'hFF; bus.g = 8'hFF; bus.b = 8'hFF;
            @(posedge clk); #1;
        end
    endtask

    // horizontal blanking tail; blanked pixels are driven white on purpose
    task automatic tail(input logic vs, input int n);
        for (int c = 0; c < n; c++) pix(vs, !(c >= 2 && c < 6), 1'b0, 8'hFF);
    endtask

    task automatic send_frame(input int nlines, input int short_row);
        int len;
        for (int l = 0; l < 2; l++) tail(1'b0, H + 8);
        for (int l = 0; l < 2; l++) tail(1'b1, H + 8);
        for (int row = 0; row < nlines; row++) begin
            len = (row == short_row) ? H - 1 : H;
            for (int c = 0; c < len; c++) begin
                if (row == arm_row && c == 0) bus.arm = 1'b1;
                if (row == reset_row && c == 0) reset = 1'b1;
                pix(1'b1, 1'b1, 1'b1, level_at(c, row));
                bus.arm = 1'b0;
                reset = 1'b0;
            end
            tail(1'b1, 8);
        end
        tail(1'b1, H + 8);
    endtask

    // vSync falling pixel, then wait (bounded) for done
    task automatic end_frame(input bit expect_done, input bit arm_on_done);
        int  n;
        bit  seen;
        bus.pix_en = 1'b1; bus.vSync = 1'b0; bus.hSync = 1'b1; bus.vgaBlankn = 1'b0;
        bus.r = 8'h00; bus.g = 8'h00; bus.b = 8'h00;
        @(posedge clk); #1;
        bus.pix_en = 1'b0;
        n = 0; seen = 1'b0;
        while (n < 8 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1'b1;
        end
        if (expect_done) begin
            chk("done_seen", 32'(seen), 1);
            chk("done_latency", n, 2);
        end else begin
            chk("no_done_after_reset", 32'(seen), 0);
        end
        if (seen) begin
            if (arm_on_done) bus.arm = 1'b1;
            @(posedge clk); #1;
            bus.arm = 1'b0;
            @(negedge clk);
            chk("done_one_cycle", 32'(bus.done), 0);
            chk("busy_after_done", 32'(bus.busy), 0);
        end
    endtask

    task automatic arm_pulse();
        bus.arm = 1'b1;
        @(posedge clk); #1;
        bus.arm = 1'b0;
        @(negedge clk);
        chk("busy_on_arm", 32'(bus.busy), 1);
        chk("hit_cleared_on_arm", 32'(bus.hit), 0);
        chk("err_cleared_on_arm", 32'(bus.frame_err), 0);
        chk("cnt_cleared_on_arm", 32'(bus.hit_count), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_res(input string t, input int h, input int hx, input int hy,
                             input int e, input int cnt);
        chk({t, "_hit"}, 32'(bus.hit), h);
        chk({t, "_hit_x"}, 32'(bus.hit_x), hx);
        chk({t, "_hit_y"}, 32'(bus.hit_y), hy);
        chk({t, "_frame_err"}, 32'(bus.frame_err), e);
        chk({t, "_hit_count"}, 32'(bus.hit_count), exp_cnt(cnt));
        chk({t, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.pix_en = 1'b0; bus.vSync = 1'b1; bus.hSync = 1'b1; bus.vgaBlankn = 1'b0;
        bus.r = 8'h00; bus.g = 8'h00; bus.b = 8'h00; bus.arm = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        check_res("rst", 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // all-black frame
        arm_pulse();
        send_frame(V, -1);
        end_frame(1'b1, 1'b0);
        check_res("black", 0, 0, 0, 0, 0);

        // single white pixel; arm coinciding with done must be ignored
        spot_x = {16}; spot_y = {12}; spot_v = {255};
        arm_pulse();
        send_frame(V, -1);
        end_frame(1'b1, 1'b1);
        check_res("single", 1, 16, 12, 0, 1);
        repeat (20) @(posedge clk);
        #1;
        check_res("single_hold", 1, 16, 12, 0, 1);

        // first hit wins
        spot_x = {10, 30}; spot_y = {5, 20}; spot_v = {255, 255};
        arm_pulse();
        send_frame(V, -1);
        end_frame(1'b1, 1'b0);
        check_res("first_wins", 1, 10, 5, 0, 2);

        // short line
        spot_x = {}; spot_y = {}; spot_v = {};
        arm_pulse();
        send_frame(V, 10);
        end_frame(1'b1, 1'b0);
        check_res("short_line", 0, 0, 0, 1, 0);

        // one line missing
        arm_pulse();
        send_frame(V - 1, -1);
        end_frame(1'b1, 1'b0);
        check_res("short_frame", 0, 0, 0, 1, 0);

        // luma boundary: 199 grey earlier, 200 grey later
        spot_x = {2, 5}; spot_y = {2, 7}; spot_v = {199, 200};
        arm_pulse();
        send_frame(V, -1);
        end_frame(1'b1, 1'b0);
        check_res("luma_edge", 1, 5, 7, 0, 1);

        // sparse pix_en with white garbage between strobes; last pixel bright
        spot_x = {31}; spot_y = {23}; spot_v = {255};
        gap = 1;
        arm_pulse();
        send_frame(V, -1);
        gap = 0;
        end_frame(1'b1, 1'b0);
        check_res("sparse_pix", 1, 31, 23, 0, 1);

        // second arm during capture ignored
        spot_x = {4}; spot_y = {6}; spot_v = {255};
        dc0 = done_cnt;
        arm_row = 5;
        arm_pulse();
        send_frame(V, -1);
        arm_row = -1;
        end_frame(1'b1, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chk("one_done_only", done_cnt - dc0, 1);
        check_res("rearm_ignored", 1, 4, 6, 0, 1);

        // reset mid-capture after a hit was already latched
        spot_x = {1}; spot_y = {1}; spot_v = {255};
        dc0 = done_cnt;
        reset_row = 12;
        arm_pulse();
        send_frame(V, -1);
        reset_row = -1;
        end_frame(1'b0, 1'b0);
        chk("reset_no_done", done_cnt - dc0, 0);
        check_res("after_reset", 0, 0, 0, 0, 0);

        // fresh capture after reset
        spot_x = {7}; spot_y = {9}; spot_v = {255};
        arm_pulse();
        send_frame(V, -1);
        end_frame(1'b1, 1'b0);
        check_res("fresh", 1, 7, 9, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
